// File: rtl/alu_seq.sv
// alu_seq: registered RV32I/RV32M integer ALU with a valid/ready handshake.
// Base ops finish one cycle after they are accepted. MUL*/DIV*/REM* iterate
// one bit per cycle over XLEN cycles on a shared shift-add / restoring-divide
// datapath, with single-cycle fast paths for divide-by-zero and signed overflow.
//
// Ports:
//   I_clk, I_rstn         clock (rising edge), async active-low reset
//   I_valid / O_ready     request handshake; O_ready is high only in IDLE
//   I_op[4:0]             op select (0..10 base, 16..23 mul/div)
//   I_data1, I_data2      operands (rs1, rs2/imm)
//   I_flush               abort any op in flight; also blocks acceptance
//   O_valid               one-cycle pulse when O_data holds a new result
//   O_data                result, held between pulses
//   O_busy                an iterative op is in progress
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            I_clk,
  input  logic            I_rstn,
  input  logic            I_valid,
  output logic            O_ready,
  input  logic [4:0]      I_op,
  input  logic [XLEN-1:0] I_data1,
  input  logic [XLEN-1:0] I_data2,
  input  logic            I_flush,
  output logic            O_valid,
  output logic [XLEN-1:0] O_data,
  output logic            O_busy
);

  localparam int CW = SHW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] p_q, p_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              is_div_q, is_div_d;
  logic              sel_q, sel_d;
  logic              neg_q, neg_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   data_q, data_d;

  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   base_res;
  logic              op_iter, op_div, sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0]   mag1, mag2, fast_res;
  logic              div_zero, div_ovf;

  logic [XLEN:0]     mul_sum, div_tmp, div_diff;
  logic              q_bit;
  logic [XLEN-1:0]   div_rem, div_val, final_res;
  logic [2*XLEN-1:0] step_next, prod;

  // Decode of the incoming request: base result, operand magnitudes and fast paths.
  always_comb begin
    shamt    = I_data2[SHW-1:0];
    base_res = '1;
    case (I_op)
      5'd0:    base_res = I_data1 + I_data2;
      5'd1:    base_res = I_data1 - I_data2;
      5'd2:    base_res = I_data1 << shamt;
      5'd3:    base_res = {{(XLEN-1){1'b0}}, $signed(I_data1) < $signed(I_data2)};
      5'd4:    base_res = {{(XLEN-1){1'b0}}, I_data1 < I_data2};
      5'd5:    base_res = I_data1 ^ I_data2;
      5'd6:    base_res = I_data1 >> shamt;
      5'd7:    base_res = $signed(I_data1) >>> shamt;
      5'd8:    base_res = I_data1 | I_data2;
      5'd9:    base_res = I_data1 & I_data2;
      5'd10:   base_res = I_data2;
      default: base_res = '1;
    endcase

    // Ops 16..23; bit 2 separates divide/remainder from multiply.
    op_iter = (I_op[4:3] == 2'b10);
    op_div  = I_op[2];
    // MULH and MULHSU treat rs1 as signed, only MULH treats rs2 as signed.
    // DIV and REM (even codes) are signed in both operands.
    sgn1    = op_div ? ~I_op[0] : ((I_op[1:0] == 2'b01) || (I_op[1:0] == 2'b10));
    sgn2    = op_div ? ~I_op[0] : (I_op[1:0] == 2'b01);
    neg1    = sgn1 & I_data1[XLEN-1];
    neg2    = sgn2 & I_data2[XLEN-1];
    mag1    = neg1 ? -I_data1 : I_data1;
    mag2    = neg2 ? -I_data2 : I_data2;

    div_zero = op_div && (I_data2 == '0);
    div_ovf  = op_div && ~I_op[0] && (I_data1 == {1'b1, {(XLEN-1){1'b0}}}) && (I_data2 == '1);
    // I_op[1] picks REM/REMU over DIV/DIVU.
    if (div_zero) fast_res = I_op[1] ? I_data1 : '1;
    else          fast_res = I_op[1] ? '0 : I_data1;
  end

  // One iteration of the shared datapath, plus sign fix-up of the final step.
  always_comb begin
    mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    // Restoring divide: bring in the next dividend bit and try subtracting.
    div_tmp  = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_diff = div_tmp - {1'b0, b_q};
    q_bit    = ~div_diff[XLEN];
    div_rem  = q_bit ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0];
    if (is_div_q) step_next = {div_rem, p_q[XLEN-2:0], q_bit};
    else          step_next = {mul_sum, p_q[XLEN-1:1]};

    prod    = neg_q ? -step_next : step_next;
    div_val = sel_q ? step_next[2*XLEN-1:XLEN] : step_next[XLEN-1:0];
    if (is_div_q)   final_res = neg_q ? -div_val : div_val;
    else if (sel_q) final_res = prod[2*XLEN-1:XLEN];
    else            final_res = prod[XLEN-1:0];
  end

  // Next-state logic: IDLE accepts requests, BUSY runs XLEN steps or aborts on flush.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    sel_d    = sel_q;
    neg_d    = neg_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (I_valid && !I_flush) begin
          if (op_iter && !div_zero && !div_ovf) begin
            state_d  = BUSY;
            cnt_d    = CW'(XLEN);
            p_d      = {{XLEN{1'b0}}, mag1};
            b_d      = mag2;
            is_div_d = op_div;
            sel_d    = op_div ? I_op[1] : (I_op[1:0] != 2'b00);
            // Remainder takes the dividend's sign; everything else the product of signs.
            neg_d    = (op_div && I_op[1]) ? neg1 : (neg1 ^ neg2);
          end else begin
            valid_d = 1'b1;
            data_d  = op_iter ? fast_res : base_res;
          end
        end
      end
      BUSY: begin
        if (I_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          p_d   = step_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            valid_d = 1'b1;
            data_d  = final_res;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rstn) begin
    if (!I_rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      sel_q    <= 1'b0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      sel_q    <= sel_d;
      neg_q    <= neg_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign O_valid = valid_q;
  assign O_data  = data_q;
  assign O_busy  = (state_q == BUSY);
  assign O_ready = (state_q == IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq. A 32-bit instance is driven by
// directed and random ops and compared to a wide-arithmetic reference model;
// a 16-bit instance covers the parameterised width.
module tb_alu_seq;

  logic        I_clk = 1'b0;
  logic        I_rstn;
  logic        I_valid, I_flush;
  logic [4:0]  I_op;
  logic [31:0] I_data1, I_data2;
  logic        O_valid, O_ready, O_busy;
  logic [31:0] O_data;

  logic        valid_16;
  logic [4:0]  op_16;
  logic [15:0] data1_16, data2_16;
  logic        o_valid_16, o_ready_16, o_busy_16;
  logic [15:0] o_data_16;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_data;

  always #5 I_clk = ~I_clk;

  alu_seq #(.XLEN(32)) dut (
    .I_clk(I_clk), .I_rstn(I_rstn), .I_valid(I_valid), .O_ready(O_ready),
    .I_op(I_op), .I_data1(I_data1), .I_data2(I_data2), .I_flush(I_flush),
    .O_valid(O_valid), .O_data(O_data), .O_busy(O_busy)
  );

  alu_seq #(.XLEN(16)) dut16 (
    .I_clk(I_clk), .I_rstn(I_rstn), .I_valid(valid_16), .O_ready(o_ready_16),
    .I_op(op_16), .I_data1(data1_16), .I_data2(data2_16), .I_flush(1'b0),
    .O_valid(o_valid_16), .O_data(o_data_16), .O_busy(o_busy_16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Architectural meaning of each op computed with 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return {31'd0, $signed(a) < $signed(b)};
      5'd4:  return {31'd0, a < b};
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  return $signed(a) >>> b[4:0];
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return b;
      5'd16: begin p = ua * ub; return p[31:0]; end
      5'd17: begin p = sa * sb; return p[63:32]; end
      5'd18: begin p = sa * longint'(ub); return p[63:32]; end
      5'd19: begin p = ua * ub; return p[63:32]; end
      5'd20: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      5'd23: return (b == 0) ? a : a % b;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic int expLatency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 5'd16 || op > 5'd23) return 1;
    if (op >= 5'd20 && b == 0) return 1;
    if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issues one op and waits for its result; optional I_valid noise while busy.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit noise, output logic [31:0] res, output int lat,
                               output int ready_low, output logic ready_at_valid);
    int guard = 0;
    while (!O_ready && guard < 100) begin
      @(posedge I_clk); #1; guard++;
    end
    I_valid = 1'b1; I_op = op; I_data1 = a; I_data2 = b;
    @(posedge I_clk); #1;
    I_valid = 1'b0; I_data1 = $urandom; I_data2 = $urandom;
    lat = 1; ready_low = 0;
    while (!O_valid && lat < 100) begin
      if (!O_ready) ready_low++;
      if (noise) begin
        I_valid = $urandom_range(0, 1) == 1; I_op = 5'd0;
      end
      @(posedge I_clk); #1; lat++;
    end
    I_valid = 1'b0;
    res = O_data;
    ready_at_valid = O_ready;
  endtask

  task automatic runOp(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
    logic [31:0] res, exp_res;
    int lat, rlow, exp_lat;
    logic rdy;
    exp_res = refModel(op, a, b);
    exp_lat = expLatency(op, a, b);
    applyStimulus(op, a, b, noise, res, lat, rlow, rdy);
    checkOutput({tag, " data"}, 64'(res), 64'(exp_res));
    checkOutput({tag, " latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, " ready-low cycles"}, 64'(rlow), 64'(exp_lat - 1));
    checkOutput({tag, " ready with result"}, 64'(rdy), 64'd1);
    last_data = exp_res;
  endtask

  task automatic applyStimulus16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] res, output int lat);
    valid_16 = 1'b1; op_16 = op; data1_16 = a; data2_16 = b;
    @(posedge I_clk); #1;
    valid_16 = 1'b0;
    lat = 1;
    while (!o_valid_16 && lat < 100) begin
      @(posedge I_clk); #1; lat++;
    end
    res = o_data_16;
  endtask

  function automatic logic [4:0] pickOp();
    int r = $urandom_range(0, 22);
    if (r <= 10) return 5'(r);
    if (r <= 18) return 5'(16 + (r - 11));
    case (r)
      19: return 5'd11;
      20: return 5'd15;
      21: return 5'd24;
      default: return 5'd31;
    endcase
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0]  b2b_op  [4];
    logic [31:0] b2b_a   [4];
    logic [31:0] b2b_b   [4];
    logic [31:0] res16;
    int          lat16, pulses;

    I_rstn = 1'b0; I_valid = 1'b0; I_flush = 1'b0; I_op = '0; I_data1 = '0; I_data2 = '0;
    valid_16 = 1'b0; op_16 = '0; data1_16 = '0; data2_16 = '0;
    last_data = '0;

    repeat (2) @(posedge I_clk);
    #1;
    checkOutput("reset O_ready", 64'(O_ready), 64'd1);
    checkOutput("reset O_valid", 64'(O_valid), 64'd0);
    checkOutput("reset O_busy", 64'(O_busy), 64'd0);
    checkOutput("reset O_data", 64'(O_data), 64'd0);
    I_rstn = 1'b1;
    @(posedge I_clk); #1;

    // Back-to-back base ops: one result per cycle, ready never drops.
    b2b_op = '{5'd0, 5'd7, 5'd2, 5'd4};
    b2b_a  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h1, 32'hFFFF_FFFF};
    b2b_b  = '{32'h1, 32'd4, 32'd33, 32'h1};
    I_valid = 1'b1; I_op = b2b_op[0]; I_data1 = b2b_a[0]; I_data2 = b2b_b[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge I_clk); #1;
      checkOutput($sformatf("b2b[%0d] valid", i), 64'(O_valid), 64'd1);
      checkOutput($sformatf("b2b[%0d] data", i), 64'(O_data), 64'(refModel(b2b_op[i], b2b_a[i], b2b_b[i])));
      checkOutput($sformatf("b2b[%0d] ready", i), 64'(O_ready), 64'd1);
      if (i < 3) begin
        I_op = b2b_op[i+1]; I_data1 = b2b_a[i+1]; I_data2 = b2b_b[i+1];
      end else begin
        I_valid = 1'b0;
      end
    end
    checkOutput("b2b SRA const", 64'(refModel(5'd7, 32'h8000_0000, 32'd4)), 64'hF800_0000);

    // Multiply and divide directed cases, including fast paths.
    runOp("MUL -2*3",     5'd16, 32'hFFFF_FFFE, 32'd3, 1'b0);
    runOp("MULH -2*3",    5'd17, 32'hFFFF_FFFE, 32'd3, 1'b0);
    runOp("MULHU max",    5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    runOp("MULHSU -1*2",  5'd18, 32'hFFFF_FFFF, 32'd2, 1'b0);
    runOp("DIV -7/2",     5'd20, 32'hFFFF_FFF9, 32'd2, 1'b0);
    runOp("REM -7/2",     5'd22, 32'hFFFF_FFF9, 32'd2, 1'b0);
    runOp("DIVU 7/0",     5'd21, 32'd7, 32'd0, 1'b0);
    runOp("REMU 7/0",     5'd23, 32'd7, 32'd0, 1'b0);
    runOp("DIV ovf",      5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    runOp("REM ovf",      5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush during BUSY cycle 10 of DIVU 100/7.
    I_valid = 1'b1; I_op = 5'd21; I_data1 = 32'd100; I_data2 = 32'd7;
    @(posedge I_clk); #1;
    I_valid = 1'b0;
    for (int j = 1; j < 10; j++) begin
      @(posedge I_clk); #1;
    end
    checkOutput("flush busy before", 64'(O_busy), 64'd1);
    I_flush = 1'b1;
    @(posedge I_clk); #1;
    I_flush = 1'b0;
    checkOutput("flush ready", 64'(O_ready), 64'd1);
    checkOutput("flush valid", 64'(O_valid), 64'd0);
    checkOutput("flush data held", 64'(O_data), 64'(last_data));
    pulses = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge I_clk); #1;
      if (O_valid) pulses++;
    end
    checkOutput("flush no result", 64'(pulses), 64'd0);
    runOp("ADD after flush", 5'd0, 32'd2, 32'd3, 1'b0);

    // Asynchronous reset in the middle of a MUL.
    I_valid = 1'b1; I_op = 5'd16; I_data1 = 32'd9; I_data2 = 32'd9;
    @(posedge I_clk); #1;
    I_valid = 1'b0;
    repeat (5) @(posedge I_clk);
    #3;
    I_rstn = 1'b0;
    #1;
    checkOutput("midreset O_ready", 64'(O_ready), 64'd1);
    checkOutput("midreset O_busy", 64'(O_busy), 64'd0);
    checkOutput("midreset O_valid", 64'(O_valid), 64'd0);
    checkOutput("midreset O_data", 64'(O_data), 64'd0);
    @(posedge I_clk); #1;
    I_rstn = 1'b1;
    @(posedge I_clk); #1;
    runOp("MUL 3*5 noisy", 5'd16, 32'd3, 32'd5, 1'b1);
    pulses = 0;
    for (int j = 0; j < 5; j++) begin
      @(posedge I_clk); #1;
      if (O_valid) pulses++;
    end
    checkOutput("no extra result", 64'(pulses), 64'd0);

    // Randomized ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [4:0]  op;
      logic [31:0] a, b;
      op = pickOp(); a = pickOperand(); b = pickOperand();
      runOp($sformatf("rand[%0d] op%0d", n, op), op, a, b, 1'b0);
    end

    // 16-bit instance.
    applyStimulus16(5'd19, 16'hFFFF, 16'hFFFF, res16[15:0], lat16);
    checkOutput("x16 MULHU data", 64'(res16[15:0]), 64'hFFFE);
    checkOutput("x16 MULHU latency", 64'(lat16), 64'd17);
    @(posedge I_clk); #1;
    applyStimulus16(5'd2, 16'h0001, 16'd17, res16[15:0], lat16);
    checkOutput("x16 SLL data", 64'(res16[15:0]), 64'h0002);
    checkOutput("x16 SLL latency", 64'(lat16), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
